// File: rtl/tl_mem_slave.sv
// rtl/tl_mem_slave.sv - TileLink-UL memory slave, one outstanding request, programmable latency.
// Define TL_MEM_WRITE_EN for a RAM (Put writes); leave undefined for a ROM.
`ifndef TL_GET
`define TL_GET              3'd4
`endif
`ifndef TL_PUT_FULL_DATA
`define TL_PUT_FULL_DATA    3'd0
`endif
`ifndef TL_PUT_PARTIAL_DATA
`define TL_PUT_PARTIAL_DATA 3'd1
`endif
`ifndef TL_ACCESS_ACK
`define TL_ACCESS_ACK       3'd0
`endif
`ifndef TL_ACCESS_ACK_DATA
`define TL_ACCESS_ACK_DATA  3'd1
`endif

module tl_mem_slave #(
  parameter int          DATA_W    = 64,
  parameter int          DEPTH     = 'h40000,
  parameter logic [63:0] BASE_ADDR = 64'h0,
  parameter int          LATENCY   = 1,
  parameter int          SRC_W     = 8,
  parameter int          SIZE_W    = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  a_valid,
  output logic                  a_ready,
  input  logic [2:0]            a_opcode,
  input  logic [SIZE_W-1:0]     a_size,
  input  logic [SRC_W-1:0]      a_source,
  input  logic [63:0]           a_address,
  input  logic [DATA_W/8-1:0]   a_mask,
  input  logic [DATA_W-1:0]     a_data,
  output logic                  d_valid,
  input  logic                  d_ready,
  output logic [2:0]            d_opcode,
  output logic [1:0]            d_param,
  output logic [SIZE_W-1:0]     d_size,
  output logic [SRC_W-1:0]      d_source,
  output logic [DATA_W-1:0]     d_data,
  output logic                  d_denied
);
  localparam int BYTES = DATA_W / 8;
  localparam int OFF   = $clog2(BYTES);
  localparam int IW    = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t              state;
  logic [3:0]          ctr;
  logic [2:0]          q_op;
  logic                q_in;
  logic [IW-1:0]       q_idx;
  logic [SIZE_W-1:0]   q_size;
  logic [SRC_W-1:0]    q_source;

  logic [DATA_W-1:0]   mem [DEPTH];

  logic [63:0]         a_off, a_word;
  logic                a_in_range;
  logic [IW-1:0]       a_idx;

  logic [2:0]          cur_op;
  logic                cur_in;
  logic [IW-1:0]       cur_idx;
  logic [SIZE_W-1:0]   cur_size;
  logic [SRC_W-1:0]    cur_source;
  logic                accept, enter_resp, is_get, is_put;
  logic [DATA_W-1:0]   rd_word;
  logic [2:0]          r_op;
  logic [DATA_W-1:0]   r_data;
  logic                r_denied;

  assign d_param = 2'd0;

  // Below-base addresses are rejected explicitly so the subtraction never wraps into range.
  assign a_off      = a_address - BASE_ADDR;
  assign a_word     = a_off >> OFF;
  assign a_in_range = (a_address >= BASE_ADDR) && (a_word < 64'(DEPTH));
  assign a_idx      = a_word[IW-1:0];

  assign accept     = rst_n && (state == IDLE) && a_valid;
  assign enter_resp = (accept && (LATENCY == 1)) || (rst_n && (state == WAIT) && (ctr == 4'd1));

  // With LATENCY=1 the response is formed on the accept edge, so the live A fields stand in for the latch.
  always_comb begin
    cur_op     = q_op;
    cur_in     = q_in;
    cur_idx    = q_idx;
    cur_size   = q_size;
    cur_source = q_source;
    if (state == IDLE) begin
      cur_op     = a_opcode;
      cur_in     = a_in_range;
      cur_idx    = a_idx;
      cur_size   = a_size;
      cur_source = a_source;
    end
  end

  assign is_get  = (cur_op == `TL_GET);
  assign is_put  = (cur_op == `TL_PUT_FULL_DATA) || (cur_op == `TL_PUT_PARTIAL_DATA);
  assign rd_word = mem[cur_idx];

  always_comb begin
    r_op     = `TL_ACCESS_ACK;
    r_data   = '0;
    r_denied = 1'b1;
    if (is_get) begin
      r_op = `TL_ACCESS_ACK_DATA;
      if (cur_in) begin
        r_data   = rd_word;
        r_denied = 1'b0;
      end
    end
`ifdef TL_MEM_WRITE_EN
    else if (is_put && cur_in) begin
      r_denied = 1'b0;
    end
`endif
  end

`ifdef TL_MEM_WRITE_EN
  logic [BYTES-1:0]  q_mask, cur_mask;
  logic [DATA_W-1:0] q_data, cur_data;
  logic              wr_en;

  assign cur_mask = (state == IDLE) ? a_mask : q_mask;
  assign cur_data = (state == IDLE) ? a_data : q_data;
  assign wr_en    = enter_resp && is_put && cur_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_mask <= '0;
      q_data <= '0;
    end else if (accept) begin
      q_mask <= a_mask;
      q_data <= a_data;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < BYTES; i++) begin
        if (cur_mask[i]) mem[cur_idx][8*i +: 8] <= cur_data[8*i +: 8];
      end
    end
  end
`else
  logic unused_wr;
  assign unused_wr = ^{a_mask, a_data};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ctr      <= 4'd0;
      q_op     <= 3'd0;
      q_in     <= 1'b0;
      q_idx    <= '0;
      q_size   <= '0;
      q_source <= '0;
      a_ready  <= 1'b1;
      d_valid  <= 1'b0;
      d_opcode <= 3'd0;
      d_size   <= '0;
      d_source <= '0;
      d_data   <= '0;
      d_denied <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (a_valid) begin
            q_op     <= a_opcode;
            q_in     <= a_in_range;
            q_idx    <= a_idx;
            q_size   <= a_size;
            q_source <= a_source;
            a_ready  <= 1'b0;
            ctr      <= 4'(LATENCY - 1);
            state    <= WAIT;
          end
        end
        WAIT: begin
          ctr <= ctr - 4'd1;
        end
        RESP: begin
          if (d_ready) begin
            state   <= IDLE;
            d_valid <= 1'b0;
            a_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
      if (enter_resp) begin
        state    <= RESP;
        d_valid  <= 1'b1;
        d_opcode <= r_op;
        d_data   <= r_data;
        d_denied <= r_denied;
        d_size   <= cur_size;
        d_source <= cur_source;
      end
    end
  end

endmodule

// File: tb/tb_tl_mem_slave.sv
// tb/tb_tl_mem_slave.sv - directed bench for tl_mem_slave (DEPTH=16, BASE=0x1000, LATENCY=3).
module tb_tl_mem_slave;
  localparam logic [63:0] BASE = 64'h1000;
  localparam logic [2:0]  OP_GET = 3'd4, OP_PUTF = 3'd0, OP_PUTP = 3'd1;
  localparam logic [2:0]  OP_AA = 3'd0, OP_AAD = 3'd1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_valid, a_ready;
  logic [2:0]  a_opcode;
  logic [2:0]  a_size;
  logic [7:0]  a_source;
  logic [63:0] a_address;
  logic [7:0]  a_mask;
  logic [63:0] a_data;
  logic        d_valid, d_ready;
  logic [2:0]  d_opcode;
  logic [1:0]  d_param;
  logic [2:0]  d_size;
  logic [7:0]  d_source;
  logic [63:0] d_data;
  logic        d_denied;

  int n_total = 0;
  int n_pass  = 0;
  int lat;
  logic        ok;
  logic [63:0] snap_data;
  logic [7:0]  snap_src;

  tl_mem_slave #(.DATA_W(64), .DEPTH(16), .BASE_ADDR(BASE), .LATENCY(3), .SRC_W(8), .SIZE_W(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode), .a_size(a_size),
    .a_source(a_source), .a_address(a_address), .a_mask(a_mask), .a_data(a_data),
    .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode), .d_param(d_param),
    .d_size(d_size), .d_source(d_source), .d_data(d_data), .d_denied(d_denied)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Drives one request, scrambles A after accept, and waits (bounded) for d_valid.
  task automatic send(input logic [2:0] op, input logic [63:0] addr, input logic [7:0] mask,
                      input logic [63:0] data, input logic [7:0] src, input logic [2:0] size,
                      output int l);
    @(negedge clk);
    a_valid = 1'b1; a_opcode = op; a_address = addr; a_mask = mask;
    a_data = data; a_source = src; a_size = size;
    @(posedge clk); #1;
    a_valid = 1'b0; a_opcode = OP_PUTF; a_address = BASE; a_mask = 8'hFF;
    a_data = 64'hFFFF_FFFF_FFFF_FFFF; a_source = 8'hEE; a_size = 3'd0;
    l = 0;
    while (1) begin
      @(negedge clk);
      l++;
      if (d_valid === 1'b1) break;
      if (l > 40) begin
        chk("timeout_d_valid", 64'(l), 64'd3);
        break;
      end
    end
  endtask

  task automatic after_hs();
    @(negedge clk);
    chk("post_hs_d_valid", 64'(d_valid), 64'd0);
    chk("post_hs_a_ready", 64'(a_ready), 64'd1);
  endtask

  initial begin
    rst_n = 1'b0; a_valid = 1'b0; d_ready = 1'b1;
    a_opcode = 3'd0; a_size = 3'd0; a_source = 8'd0; a_address = 64'd0;
    a_mask = 8'd0; a_data = 64'd0;
    for (int i = 0; i < 16; i++) dut.mem[i] = 64'd0;
    dut.mem[0] = 64'h0123_4567_89AB_CDEF;
    dut.mem[1] = 64'hDEAD_BEEF_0123_4567;
    dut.mem[2] = 64'hAAAA_BBBB_CCCC_DDDD;

    repeat (2) @(negedge clk);
    chk("rst_a_ready",  64'(a_ready),  64'd1);
    chk("rst_d_valid",  64'(d_valid),  64'd0);
    chk("rst_d_data",   d_data,        64'd0);
    chk("rst_d_denied", 64'(d_denied), 64'd0);
    chk("rst_d_opcode", 64'(d_opcode), 64'd0);
    chk("rst_d_size",   64'(d_size),   64'd0);
    chk("rst_d_source", 64'(d_source), 64'd0);
    chk("rst_d_param",  64'(d_param),  64'd0);
    rst_n = 1'b1;

    // Get word 1 at BASE+8
    send(OP_GET, BASE + 64'd8, 8'hFF, 64'd0, 8'h5A, 3'd3, lat);
    chk("get1_latency", 64'(lat),      64'd3);
    chk("get1_data",    d_data,        64'hDEAD_BEEF_0123_4567);
    chk("get1_denied",  64'(d_denied), 64'd0);
    chk("get1_opcode",  64'(d_opcode), 64'(OP_AAD));
    chk("get1_source",  64'(d_source), 64'h5A);
    chk("get1_size",    64'(d_size),   64'd3);
    chk("get1_a_ready", 64'(a_ready),  64'd0);
    after_hs();

    // Backpressure: d_ready low for 5 cycles
    d_ready = 1'b0;
    send(OP_GET, BASE, 8'hFF, 64'd0, 8'h21, 3'd2, lat);
    chk("bp_latency", 64'(lat), 64'd3);
    chk("bp_data",    d_data,   64'h0123_4567_89AB_CDEF);
    chk("bp_size",    64'(d_size), 64'd2);
    snap_data = d_data; snap_src = d_source;
    ok = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (d_valid !== 1'b1 || a_ready !== 1'b0 || d_data !== snap_data || d_source !== snap_src) ok = 1'b0;
    end
    chk("bp_stable", 64'(ok), 64'd1);
    d_ready = 1'b1;
    after_hs();

    // First address past the end, then in-range Gets
    send(OP_GET, BASE + 64'd128, 8'hFF, 64'd0, 8'h03, 3'd3, lat);
    chk("oor_denied", 64'(d_denied), 64'd1);
    chk("oor_data",   d_data,        64'd0);
    chk("oor_opcode", 64'(d_opcode), 64'(OP_AAD));
    after_hs();
    send(OP_GET, BASE + 64'd9, 8'hFF, 64'd0, 8'h04, 3'd0, lat);
    chk("after_oor_data",   d_data,        64'hDEAD_BEEF_0123_4567);
    chk("after_oor_denied", 64'(d_denied), 64'd0);
    after_hs();
    send(OP_GET, BASE + 64'h78, 8'hFF, 64'd0, 8'h05, 3'd3, lat);
    chk("last_word_data",   d_data,        64'd0);
    chk("last_word_denied", 64'(d_denied), 64'd0);
    after_hs();
    send(OP_GET, BASE - 64'd8, 8'hFF, 64'd0, 8'h06, 3'd3, lat);
    chk("below_base_denied", 64'(d_denied), 64'd1);
    chk("below_base_data",   d_data,        64'd0);
    after_hs();

    // Unsupported opcode
    send(3'd2, BASE, 8'hFF, 64'h1234, 8'h07, 3'd3, lat);
    chk("badop_opcode", 64'(d_opcode), 64'(OP_AA));
    chk("badop_denied", 64'(d_denied), 64'd1);
    chk("badop_data",   d_data,        64'd0);
    after_hs();

`ifdef TL_MEM_WRITE_EN
    send(OP_PUTP, BASE + 64'd16, 8'h0F, 64'h1111_2222_3333_4444, 8'h08, 3'd3, lat);
    chk("putp_opcode", 64'(d_opcode), 64'(OP_AA));
    chk("putp_denied", 64'(d_denied), 64'd0);
    after_hs();
    send(OP_GET, BASE + 64'd16, 8'hFF, 64'd0, 8'h09, 3'd3, lat);
    chk("putp_readback", d_data, 64'hAAAA_BBBB_3333_4444);
    after_hs();
    send(OP_PUTF, BASE + 64'd128, 8'hFF, 64'h5555, 8'h0A, 3'd3, lat);
    chk("put_oor_denied", 64'(d_denied), 64'd1);
    after_hs();
`else
    send(OP_PUTF, BASE, 8'hFF, 64'h5555_6666_7777_8888, 8'h08, 3'd3, lat);
    chk("rom_put_opcode", 64'(d_opcode), 64'(OP_AA));
    chk("rom_put_denied", 64'(d_denied), 64'd1);
    chk("rom_put_data",   d_data,        64'd0);
    after_hs();
    send(OP_GET, BASE, 8'hFF, 64'd0, 8'h09, 3'd3, lat);
    chk("rom_readback", d_data, 64'h0123_4567_89AB_CDEF);
    after_hs();
`endif

    // Reset while the request is in WAIT
    @(negedge clk);
    a_valid = 1'b1; a_opcode = OP_GET; a_address = BASE + 64'd8; a_source = 8'h33; a_size = 3'd3;
    @(posedge clk); #1;
    a_valid = 1'b0;
    @(negedge clk);
    chk("wait_a_ready", 64'(a_ready), 64'd0);
    rst_n = 1'b0;
    #1;
    chk("midrst_a_ready", 64'(a_ready), 64'd1);
    chk("midrst_d_valid", 64'(d_valid), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ok = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (d_valid !== 1'b0 || a_ready !== 1'b1) ok = 1'b0;
    end
    chk("dropped_no_resp", 64'(ok), 64'd1);

    send(OP_GET, BASE + 64'd8, 8'hFF, 64'd0, 8'h44, 3'd3, lat);
    chk("post_rst_latency", 64'(lat),      64'd3);
    chk("post_rst_data",    d_data,        64'hDEAD_BEEF_0123_4567);
    chk("post_rst_source",  64'(d_source), 64'h44);
    after_hs();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
